// File: rtl/td4_core_param.sv
// Parametrised TD4 accumulator CPU core: DATA_W-bit A/B registers, writable 2^ADDR_W-word
// program memory, IDLE/RUN/STEP/HALT control. Opcode 1100 is HALT only when TD4_HALT_EN is defined.
module td4_core_param #(
   parameter int DATA_W = 4,
   parameter int ADDR_W = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              step,
   input  logic              prog_we,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [DATA_W+3:0] prog_data,
   input  logic [DATA_W-1:0] in_port,
   output logic [DATA_W-1:0] out_port,
   output logic [ADDR_W-1:0] pc,
   output logic              carry,
   output logic              halted,
   output logic              busy
);

   localparam int MEM_D = 1 << ADDR_W;

   localparam logic [3:0] OP_ADD_A   = 4'b0000;
   localparam logic [3:0] OP_MOV_AB  = 4'b0001;
   localparam logic [3:0] OP_IN_A    = 4'b0010;
   localparam logic [3:0] OP_MOV_AI  = 4'b0011;
   localparam logic [3:0] OP_MOV_BA  = 4'b0100;
   localparam logic [3:0] OP_ADD_B   = 4'b0101;
   localparam logic [3:0] OP_IN_B    = 4'b0110;
   localparam logic [3:0] OP_MOV_BI  = 4'b0111;
   localparam logic [3:0] OP_OUT_B   = 4'b1001;
   localparam logic [3:0] OP_OUT_IM  = 4'b1011;
   localparam logic [3:0] OP_HALT    = 4'b1100;
   localparam logic [3:0] OP_JNC     = 4'b1110;
   localparam logic [3:0] OP_JMP     = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_STEP,
      ST_HALT
   } state_t;

   generate
      if (ADDR_W > DATA_W) begin : g_bad_widths
         $error("td4_core_param: ADDR_W must not exceed DATA_W");
      end
   endgenerate

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   a_q, a_d;
   logic [DATA_W-1:0]   b_q, b_d;
   logic [DATA_W-1:0]   out_q, out_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic                carry_q, carry_d;
   logic                busy_q, busy_d;
   logic [DATA_W+3:0]   mem_q [MEM_D];

   logic                mem_we;
   logic [DATA_W+3:0]   instr;
   logic [3:0]          op;
   logic [DATA_W-1:0]   imm;
   logic [DATA_W-1:0]   src;
   logic [DATA_W:0]     sum;
   logic [ADDR_W-1:0]   pc_inc;
   logic                exec;
   logic                halt_op;

   // Instruction decode and ALU: fetch is combinational from the current pc.
   always_comb begin
      instr  = mem_q[pc_q];
      op     = instr[DATA_W+3:DATA_W];
      imm    = instr[DATA_W-1:0];
      pc_inc = pc_q + ADDR_W'(1);
      exec   = (state_q == ST_RUN) || (state_q == ST_STEP);

      src = '0;
      case (op)
         OP_ADD_A, OP_MOV_BA:  src = a_q;
         OP_ADD_B, OP_MOV_AB,
         OP_OUT_B:             src = b_q;
         OP_IN_A, OP_IN_B:     src = in_port;
         default:              src = '0;
      endcase
      sum = {1'b0, src} + {1'b0, imm};

`ifdef TD4_HALT_EN
      halt_op = (op == OP_HALT);
`else
      halt_op = 1'b0;
`endif
   end

   // Architectural register updates for the instruction being retired.
   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      out_d   = out_q;
      pc_d    = pc_q;
      carry_d = carry_q;
      if (exec) begin
         pc_d = pc_inc;
         case (op)
            OP_ADD_A, OP_MOV_AI, OP_MOV_AB, OP_IN_A: begin
               a_d     = sum[DATA_W-1:0];
               carry_d = sum[DATA_W];
            end
            OP_ADD_B, OP_MOV_BI, OP_MOV_BA, OP_IN_B: begin
               b_d     = sum[DATA_W-1:0];
               carry_d = sum[DATA_W];
            end
            OP_OUT_B, OP_OUT_IM: begin
               out_d   = sum[DATA_W-1:0];
               carry_d = sum[DATA_W];
            end
            OP_JMP: begin
               pc_d    = sum[ADDR_W-1:0];
               carry_d = sum[DATA_W];
            end
            // The branch condition is the flag as it stood before this instruction.
            OP_JNC: begin
               if (!carry_q) pc_d = sum[ADDR_W-1:0];
               carry_d = sum[DATA_W];
            end
            default: ;
         endcase
      end
   end

   // Control FSM: memory is only writable while the core is not executing.
   always_comb begin
      state_d = state_q;
      mem_we  = 1'b0;
      case (state_q)
         ST_IDLE, ST_HALT: begin
            mem_we = prog_we;
            if (start)     state_d = ST_RUN;
            else if (step) state_d = ST_STEP;
         end
         ST_RUN: begin
            if (halt_op) state_d = ST_HALT;
         end
         ST_STEP: begin
            state_d = halt_op ? ST_HALT : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d == ST_RUN) || (state_d == ST_STEP);
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         out_q   <= '0;
         pc_q    <= '0;
         carry_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         out_q   <= out_d;
         pc_q    <= pc_d;
         carry_q <= carry_d;
         busy_q  <= busy_d;
      end
   end

   always_ff @(posedge clock) begin
      if (mem_we) mem_q[prog_addr] <= prog_data;
   end

`ifdef TD4_HALT_EN
   logic halted_q, halted_d;

   always_comb begin
      halted_d = (state_d == ST_HALT);
   end

   always_ff @(posedge clock) begin
      if (!reset) halted_q <= 1'b0;
      else        halted_q <= halted_d;
   end

   assign halted = halted_q;
`else
   assign halted = 1'b0;
`endif

   assign out_port = out_q;
   assign pc       = pc_q;
   assign carry    = carry_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_td4_core_param.sv
// Directed self-checking bench for td4_core_param (DATA_W=4, ADDR_W=4).
module tb_td4_core_param;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic       step = 1'b0;
   logic       prog_we = 1'b0;
   logic [3:0] prog_addr = '0;
   logic [7:0] prog_data = '0;
   logic [3:0] in_port = '0;
   logic [3:0] out_port;
   logic [3:0] pc;
   logic       carry;
   logic       halted;
   logic       busy;

   int checks = 0;
   int errors = 0;
   logic [7:0] prog [16];

   td4_core_param #(.DATA_W(4), .ADDR_W(4)) dut (
      .clock(clock), .reset(reset), .start(start), .step(step),
      .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
      .in_port(in_port), .out_port(out_port), .pc(pc), .carry(carry),
      .halted(halted), .busy(busy)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick();
      reset = 1'b1;
   endtask

   task automatic clear_prog();
      for (int i = 0; i < 16; i++) prog[i] = 8'h80;
   endtask

   task automatic load_all();
      for (int i = 0; i < 16; i++) begin
         prog_we = 1'b1;
         prog_addr = 4'(i);
         prog_data = prog[i];
         tick();
      end
      prog_we = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (pc !== 4'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", pc); end
      checks++; if (out_port !== 4'h0) begin errors++; $display("FAIL reset_out: got %h expected 0", out_port); end
      checks++; if (carry !== 1'b0) begin errors++; $display("FAIL reset_carry: got %b expected 0", carry); end
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
   endtask

   task automatic test_load_run();
      do_reset();
      clear_prog();
      prog[0] = 8'h3C; prog[1] = 8'h05; prog[2] = 8'h40; prog[3] = 8'h90;
      prog[4] = 8'hC0; prog[5] = 8'hF5;
      load_all();
      pulse_start();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL run_busy_start: got %b expected 1", busy); end
      checks++; if (pc !== 4'h0) begin errors++; $display("FAIL run_pc_start: got %h expected 0", pc); end
      tick();
      checks++; if (dut.a_q !== 4'hC) begin errors++; $display("FAIL run_mov_a: got %h expected c", dut.a_q); end
      checks++; if (pc !== 4'h1) begin errors++; $display("FAIL run_pc1: got %h expected 1", pc); end
      tick();
      checks++; if (dut.a_q !== 4'h1 || carry !== 1'b1) begin errors++; $display("FAIL run_add_a: got a=%h c=%b expected a=1 c=1", dut.a_q, carry); end
      tick();
      checks++; if (dut.b_q !== 4'h1 || carry !== 1'b0) begin errors++; $display("FAIL run_mov_ba: got b=%h c=%b expected b=1 c=0", dut.b_q, carry); end
      tick();
      checks++; if (out_port !== 4'h1) begin errors++; $display("FAIL run_out_b: got %h expected 1", out_port); end
      tick();
      checks++; if (pc !== 4'h5) begin errors++; $display("FAIL run_pc_after_c0: got %h expected 5", pc); end
`ifdef TD4_HALT_EN
      checks++; if (halted !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL run_halt: got halted=%b busy=%b expected 1 0", halted, busy); end
`else
      checks++; if (halted !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL run_nop_c0: got halted=%b busy=%b expected 0 1", halted, busy); end
`endif
      tick();
      tick();
      checks++; if (pc !== 4'h5) begin errors++; $display("FAIL run_pc_settled: got %h expected 5", pc); end
      do_reset();
   endtask

   task automatic test_jnc_loop();
      do_reset();
      clear_prog();
      prog[0] = 8'h01; prog[1] = 8'hE0; prog[2] = 8'hC0; prog[3] = 8'hF3;
      load_all();
      pulse_start();
      for (int i = 0; i < 31; i++) tick();
      checks++; if (dut.a_q !== 4'h0 || carry !== 1'b1) begin errors++; $display("FAIL jnc_wrap: got a=%h c=%b expected a=0 c=1", dut.a_q, carry); end
      checks++; if (pc !== 4'h1) begin errors++; $display("FAIL jnc_pc_wrap: got %h expected 1", pc); end
      tick();
      checks++; if (pc !== 4'h2 || carry !== 1'b0) begin errors++; $display("FAIL jnc_not_taken: got pc=%h c=%b expected pc=2 c=0", pc, carry); end
      tick();
      checks++; if (pc !== 4'h3) begin errors++; $display("FAIL jnc_exit_pc: got %h expected 3", pc); end
`ifdef TD4_HALT_EN
      checks++; if (halted !== 1'b1) begin errors++; $display("FAIL jnc_halted: got %b expected 1", halted); end
`else
      tick();
      checks++; if (pc !== 4'h3 || halted !== 1'b0) begin errors++; $display("FAIL jnc_no_halt: got pc=%h halted=%b expected pc=3 halted=0", pc, halted); end
`endif
      do_reset();
   endtask

   task automatic test_in_port();
      do_reset();
      clear_prog();
      prog[0] = 8'h22; prog[1] = 8'hB7; prog[2] = 8'h63; prog[3] = 8'hA0;
      prog[4] = 8'h90; prog[5] = 8'h14; prog[6] = 8'hF6;
      load_all();
      in_port = 4'h9;
      pulse_start();
      tick();
      checks++; if (dut.a_q !== 4'hB || carry !== 1'b0) begin errors++; $display("FAIL in_a: got a=%h c=%b expected a=b c=0", dut.a_q, carry); end
      in_port = 4'hF;
      tick();
      checks++; if (out_port !== 4'h7) begin errors++; $display("FAIL out_im: got %h expected 7", out_port); end
      tick();
      checks++; if (dut.b_q !== 4'h2 || carry !== 1'b1) begin errors++; $display("FAIL in_b_carry: got b=%h c=%b expected b=2 c=1", dut.b_q, carry); end
      tick();
      checks++; if (carry !== 1'b1 || pc !== 4'h4) begin errors++; $display("FAIL nop_keeps_carry: got c=%b pc=%h expected c=1 pc=4", carry, pc); end
      tick();
      checks++; if (out_port !== 4'h2 || carry !== 1'b0) begin errors++; $display("FAIL out_b: got out=%h c=%b expected out=2 c=0", out_port, carry); end
      tick();
      checks++; if (dut.a_q !== 4'h6) begin errors++; $display("FAIL mov_ab_imm: got %h expected 6", dut.a_q); end
      in_port = 4'h0;
      do_reset();
   endtask

   task automatic test_single_step();
      do_reset();
      clear_prog();
      prog[0] = 8'h35; prog[1] = 8'h77; prog[2] = 8'h31; prog[3] = 8'hF3;
      load_all();
      step = 1'b1;
      tick();
      step = 1'b0;
      checks++; if (busy !== 1'b1 || pc !== 4'h0) begin errors++; $display("FAIL step_busy: got busy=%b pc=%h expected 1 0", busy, pc); end
      prog_we = 1'b1; prog_addr = 4'h1; prog_data = 8'h3F;
      tick();
      prog_we = 1'b0;
      checks++; if (busy !== 1'b0 || pc !== 4'h1 || dut.a_q !== 4'h5) begin errors++; $display("FAIL step_done: got busy=%b pc=%h a=%h expected 0 1 5", busy, pc, dut.a_q); end
      checks++; if (dut.mem_q[1] !== 8'h77) begin errors++; $display("FAIL step_mem_protect: got %h expected 77", dut.mem_q[1]); end
      step = 1'b1;
      tick();
      step = 1'b0;
      tick();
      checks++; if (dut.b_q !== 4'h7 || dut.a_q !== 4'h5 || pc !== 4'h2 || busy !== 1'b0) begin errors++; $display("FAIL step_second: got b=%h a=%h pc=%h busy=%b expected 7 5 2 0", dut.b_q, dut.a_q, pc, busy); end
      start = 1'b1; step = 1'b1;
      tick();
      start = 1'b0; step = 1'b0;
      tick();
      checks++; if (dut.a_q !== 4'h1 || pc !== 4'h3) begin errors++; $display("FAIL start_wins_exec: got a=%h pc=%h expected 1 3", dut.a_q, pc); end
      tick();
      checks++; if (busy !== 1'b1 || pc !== 4'h3) begin errors++; $display("FAIL start_wins_run: got busy=%b pc=%h expected 1 3", busy, pc); end
      do_reset();
   endtask

   task automatic test_reset_mid_run();
      logic [3:0] exp_pc [4];
      logic [3:0] exp_a [4];
      logic       exp_c [4];
      exp_pc = '{4'h1, 4'h2, 4'h3, 4'h4};
      exp_a  = '{4'hC, 4'h1, 4'h1, 4'h1};
      exp_c  = '{1'b0, 1'b1, 1'b0, 1'b0};
      do_reset();
      clear_prog();
      prog[0] = 8'h3C; prog[1] = 8'h05; prog[2] = 8'h40; prog[3] = 8'h90; prog[4] = 8'hF4;
      load_all();
      pulse_start();
      tick();
      tick();
      do_reset();
      checks++; if (dut.a_q !== 4'h0 || dut.b_q !== 4'h0 || out_port !== 4'h0) begin errors++; $display("FAIL midrun_regs: got a=%h b=%h out=%h expected 0 0 0", dut.a_q, dut.b_q, out_port); end
      checks++; if (pc !== 4'h0 || carry !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrun_ctrl: got pc=%h c=%b busy=%b expected 0 0 0", pc, carry, busy); end
      pulse_start();
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (pc !== exp_pc[i] || dut.a_q !== exp_a[i] || carry !== exp_c[i]) begin
            errors++;
            $display("FAIL rerun_trace[%0d]: got pc=%h a=%h c=%b expected pc=%h a=%h c=%b", i, pc, dut.a_q, carry, exp_pc[i], exp_a[i], exp_c[i]);
         end
      end
      checks++; if (out_port !== 4'h1 || dut.b_q !== 4'h1) begin errors++; $display("FAIL rerun_out: got out=%h b=%h expected 1 1", out_port, dut.b_q); end
      do_reset();
   endtask

   initial begin
      test_reset();
      test_load_run();
      test_jnc_loop();
      test_in_port();
      test_single_step();
      test_reset_mid_run();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
